// File: rtl/clk_int_div_multi.sv
// Multi-channel integer clock divider with runtime-reprogrammable divisors.
// A new divisor is applied only at a period boundary, so clk_o never produces a runt pulse.
module clk_int_div_multi #(
   parameter int NUM_CH      = 4,
   parameter int DIV_WIDTH   = 16,
   parameter int DEFAULT_DIV = 2,
   parameter int DONE_DELAY  = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_CH-1:0]           en_i,
   input  logic [NUM_CH*DIV_WIDTH-1:0] div_i,
   input  logic [NUM_CH-1:0]           div_valid_i,
   output logic [NUM_CH-1:0]           div_ready_o,
   output logic [NUM_CH-1:0]           div_done_o,
   output logic [NUM_CH-1:0]           tick_o,
   output logic [NUM_CH-1:0]           clk_o
);

   localparam int                   DONE_W   = $clog2(DONE_DELAY + 1);
   localparam logic [DIV_WIDTH-1:0] DEF_DIV  = DIV_WIDTH'(DEFAULT_DIV);
   localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(2);
   localparam logic [DIV_WIDTH-1:0] ONE      = DIV_WIDTH'(1);
   localparam logic [DONE_W-1:0]    DONE_MAX = DONE_W'(DONE_DELAY);
   localparam logic [DONE_W-1:0]    DONE_ONE = DONE_W'(1);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DIV_WIDTH-1:0] d_q, d_d;
      logic [DIV_WIDTH-1:0] p_q, p_d;
      logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
      logic                 pv_q, pv_d;
      logic                 run_q, run_d;
      logic                 clk_q, clk_d;
      logic [DONE_W-1:0]    done_q, done_d;
      logic [DIV_WIDTH-1:0] div_req;
      logic                 wrap;
      logic                 accept;

      assign div_req = div_i[c*DIV_WIDTH +: DIV_WIDTH];
      assign wrap    = run_q && (cnt_q == d_q - ONE);
      assign accept  = div_valid_i[c] && !pv_q;

      always_comb begin
         // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
         d_d    = d_q;
         p_d    = p_q;
         pv_d   = pv_q;
         cnt_d  = cnt_q;
         run_d  = run_q;
         done_d = done_q;

         if (accept) begin
            p_d    = (div_req < MIN_DIV) ? MIN_DIV : div_req;
            pv_d   = 1'b1;
            done_d = '0;
         end else if (!pv_q && wrap && (done_q != DONE_MAX)) begin
            // Only ticks at the newly applied divisor count towards done.
            done_d = done_q + DONE_ONE;
         end

         if (run_q) begin
            if (wrap) begin
               cnt_d = '0;
               if (pv_q) begin
                  d_d  = p_q;
                  pv_d = 1'b0;
               end
               if (!en_i[c]) run_d = 1'b0;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end else begin
            cnt_d = '0;
            if (pv_q) begin
               d_d  = p_q;
               pv_d = 1'b0;
            end
            if (en_i[c]) run_d = 1'b1;
         end

         // Output flop is driven from next-state values, keeping clk_o free of combinational paths.
         clk_d = run_d && (cnt_d < (d_d >> 1));
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            d_q    <= DEF_DIV;
            p_q    <= DEF_DIV;
            pv_q   <= 1'b0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            clk_q  <= 1'b0;
            done_q <= DONE_MAX;
         end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            d_q    <= d_d;
            p_q    <= p_d;
            pv_q   <= pv_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            clk_q  <= clk_d;
            done_q <= done_d;
         end
      end

      assign div_ready_o[c] = ~pv_q;
      assign div_done_o[c]  = (done_q == DONE_MAX);
      assign tick_o[c]      = wrap;
      assign clk_o[c]       = clk_q;
   end

endmodule
